// File: rtl/egg_pkg.sv
// Shared constants, FSM state type and a priority helper for the egg scheduler.
package egg_pkg;

  localparam int SCREEN_W   = 96;
  localparam int SCREEN_H   = 64;
  localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;

  localparam logic [7:0] COL_LO = 8'd2;
  localparam logic [7:0] COL_HI = 8'd9;
  localparam logic [7:0] ROW_LO = 8'd2;
  localparam logic [7:0] ROW_HI = 8'd11;

  localparam logic [15:0] BG_COLOUR = 16'hFDDB;

  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] idx;
    if (v[0]) begin
      idx = 2'd0;
    end else if (v[1]) begin
      idx = 2'd1;
    end else if (v[2]) begin
      idx = 2'd2;
    end else if (v[3]) begin
      idx = 2'd3;
    end else begin
      idx = 2'd0;
    end
    return idx;
  endfunction

endpackage

// File: rtl/egg_slot_hit.sv
// Combinational test of whether the current pixel falls inside one egg's sprite box.
module egg_slot_hit
  import egg_pkg::*;
(
  input  logic [6:0] row,
  input  logic [6:0] col,
  input  logic [6:0] x,
  input  logic [6:0] y,
  input  logic       active,
  output logic       hit
);

  logic [7:0] col8;
  logic [7:0] row8;
  logic [7:0] x_lo;
  logic [7:0] x_hi;
  logic [7:0] y_lo;
  logic [7:0] y_hi;

  // Widened to 8 bits so the box edges never wrap near the screen limits.
  assign col8 = {1'b0, col};
  assign row8 = {1'b0, row};
  assign x_lo = {1'b0, x} + COL_LO;
  assign x_hi = {1'b0, x} + COL_HI;
  assign y_lo = {1'b0, y} + ROW_LO;
  assign y_hi = {1'b0, y} + ROW_HI;

  assign hit = active
             && (col8 >= x_lo) && (col8 <= x_hi)
             && (row8 >= y_lo) && (row8 <= y_hi);

endmodule

// File: rtl/egg_scheduler.sv
// Egg slot lifecycle (spawn, per-frame fall, landing) and two-stage compositing
// of the per-slot renderer pixels into the OLED stream.
module egg_scheduler
  import egg_pkg::*;
#(
  parameter int          NUM_SLOTS = 4,
  parameter int          FRAME_DIV = 4,
  parameter int          X_MAX     = 86,
  parameter int          Y_MAX     = 52,
  parameter logic [15:0] BG_COLOUR = egg_pkg::BG_COLOUR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] pixel_index,
  input  logic        spawn_valid,
  input  logic [6:0]  spawn_x,
  output logic        spawn_ready,
  output logic [27:0] slot_x,
  output logic [27:0] slot_y,
  output logic [3:0]  slot_active,
  input  logic [63:0] slot_pix,
  output logic [15:0] oled_data,
  output logic        landed,
  output logic [1:0]  landed_slot
);

  localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [6:0]  X_LIM    = 7'(X_MAX);
  localparam logic [6:0]  Y_LAND   = 7'(Y_MAX);
  localparam logic [12:0] LAST_PIX = 13'(NUM_PIXELS - 1);
  localparam logic [12:0] W13      = 13'(SCREEN_W);

  state_t                      state_r, state_n;
  logic [1:0]                  idx_r, idx_n;
  logic [3:0]                  frame_cnt_r, frame_cnt_n;
  logic [12:0]                 pix_prev_r;
  logic [NUM_SLOTS-1:0][6:0]   x_r, x_n;
  logic [NUM_SLOTS-1:0][6:0]   y_r, y_n;
  logic [NUM_SLOTS-1:0]        act_r, act_n;
  logic                        landed_r, landed_n;
  logic [1:0]                  landed_slot_r, landed_slot_n;
  logic                        ready_r, ready_n;

  logic                        tick;
  logic                        wrap;
  logic                        enter_update;
  logic                        accept;
  logic [1:0]                  free_idx;
  logic [6:0]                  spawn_x_clamped;

  logic [6:0]                  row;
  logic [6:0]                  col;
  logic [NUM_SLOTS-1:0]        hit;
  logic [NUM_SLOTS-1:0]        hit_valid;
  logic [1:0]                  sel_r;
  logic                        any_r;
  logic [15:0]                 oled_r;

  assign tick            = (pixel_index == 13'd0) && (pix_prev_r != 13'd0);
  assign wrap            = tick && (frame_cnt_r == DIV_LAST);
  assign enter_update    = wrap && (state_r == IDLE);
  // The entering tick masks ready combinationally so UPDATE always wins a collision.
  assign spawn_ready     = ready_r && !enter_update;
  assign accept          = spawn_valid && spawn_ready;
  assign free_idx        = first_set(~act_r);
  assign spawn_x_clamped = (spawn_x > X_LIM) ? X_LIM : spawn_x;

  // Frame counter advances on every tick, including ticks seen during UPDATE.
  always_comb begin
    frame_cnt_n = frame_cnt_r;
    if (wrap) begin
      frame_cnt_n = 4'd0;
    end else if (tick) begin
      frame_cnt_n = frame_cnt_r + 4'd1;
    end else begin
      frame_cnt_n = frame_cnt_r;
    end
  end

  // Slot FSM: spawns in IDLE, one slot per cycle fall/land walk in UPDATE.
  always_comb begin
    state_n       = state_r;
    idx_n         = 2'd0;
    x_n           = x_r;
    y_n           = y_r;
    act_n         = act_r;
    landed_n      = 1'b0;
    landed_slot_n = landed_slot_r;
    case (state_r)
      IDLE: begin
        if (enter_update) begin
          state_n = UPDATE;
        end else if (accept) begin
          x_n[free_idx]   = spawn_x_clamped;
          y_n[free_idx]   = 7'd0;
          act_n[free_idx] = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      UPDATE: begin
        idx_n = idx_r + 2'd1;
        if (act_r[idx_r]) begin
          if ((y_r[idx_r] + 7'd1) == Y_LAND) begin
            act_n[idx_r]  = 1'b0;
            y_n[idx_r]    = 7'd0;
            landed_n      = 1'b1;
            landed_slot_n = idx_r;
          end else begin
            y_n[idx_r] = y_r[idx_r] + 7'd1;
          end
        end else begin
          act_n[idx_r] = 1'b0;
        end
        if (idx_r == 2'd3) begin
          state_n = IDLE;
        end else begin
          state_n = UPDATE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    ready_n = (state_n == IDLE) && (act_n != {NUM_SLOTS{1'b1}});
  end

  // Control and slot state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= 2'd0;
      frame_cnt_r   <= 4'd0;
      pix_prev_r    <= 13'd0;
      x_r           <= '0;
      y_r           <= '0;
      act_r         <= {NUM_SLOTS{1'b0}};
      landed_r      <= 1'b0;
      landed_slot_r <= 2'd0;
      ready_r       <= 1'b0;
    end else begin
      state_r       <= state_n;
      idx_r         <= idx_n;
      frame_cnt_r   <= frame_cnt_n;
      pix_prev_r    <= pixel_index;
      x_r           <= x_n;
      y_r           <= y_n;
      act_r         <= act_n;
      landed_r      <= landed_n;
      landed_slot_r <= landed_slot_n;
      ready_r       <= ready_n;
    end
  end

  assign row       = 7'(pixel_index / W13);
  assign col       = 7'(pixel_index % W13);
  assign hit_valid = (pixel_index <= LAST_PIX) ? hit : {NUM_SLOTS{1'b0}};

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
    egg_slot_hit u_hit (
      .row    (row),
      .col    (col),
      .x      (x_r[g]),
      .y      (y_r[g]),
      .active (act_r[g]),
      .hit    (hit[g])
    );
  end

  // Stage 1 picks the topmost egg; stage 2 aligns with the renderers' one-cycle lag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_r  <= 2'd0;
      any_r  <= 1'b0;
      oled_r <= BG_COLOUR;
    end else begin
      sel_r  <= first_set(hit_valid);
      any_r  <= |hit_valid;
      oled_r <= any_r ? slot_pix[{sel_r, 4'd0} +: 16] : BG_COLOUR;
    end
  end

  assign slot_x      = x_r;
  assign slot_y      = y_r;
  assign slot_active = act_r;
  assign landed      = landed_r;
  assign landed_slot = landed_slot_r;
  assign oled_data   = oled_r;

endmodule

// File: doc/egg_scheduler.md
# egg_scheduler

Owns the position and lifecycle of up to four falling egg sprites on the 96x64 OLED, sequenced once per frame. Accepts spawn requests through a valid/ready handshake and moves each active egg downward every FRAME_DIV frames. It frees an egg and reports a landing when the egg reaches the floor. It also composites the per-slot egg renderer outputs into a single registered `oled_data` stream, lowest slot index on top, in front of the OLED driver.

## Interface
- NUM_SLOTS, 4: egg slots; fixed at 4 for this revision.
- FRAME_DIV, 4: frames between fall steps; legal range 1..15.
- X_MAX, 86: largest legal slot x.
- Y_MAX, 52: slot y at which an egg lands.
- BG_COLOUR, 16'hFDDB: RGB565 colour when no egg covers the pixel.
- clk  in  1  pixel clock shared with OLED driver and renderers.
- reset  in  1  asynchronous, active-high.
- pixel_index  in  13  current OLED pixel, row*96+col, 0..6143.
- spawn_valid  in  1  spawn request.
- spawn_x  in  7  requested x of new egg.
- spawn_ready  out  1  a spawn is accepted this cycle if spawn_valid is also high.
- slot_x  out  28  {x3,x2,x1,x0}, 7 b each, to the renderers' `x`.
- slot_y  out  28  {y3,y2,y1,y0}, 7 b each, to the renderers' `y`.
- slot_active  out  4  bit n set means slot n holds an egg.
- slot_pix  in  64  {p3..p0}, 16 b each, renderer outputs; each lags pixel_index by 1 cycle.
- oled_data  out  16  composited pixel.
- landed  out  1  one-cycle pulse when an egg is freed at the floor.
- landed_slot  out  2  slot freed; valid while landed=1.

## Operation
- Reset values:
  - slot_x, slot_y, slot_active, landed, landed_slot: 0.
  - oled_data: BG_COLOUR.
  - spawn_ready: 0.
  - frame_cnt: 0.
  - FSM: IDLE.
- Frame tick: a registered copy of pixel_index is kept; the tick is one cycle where pixel_index==0 and the previous value !=0. There is no tick out of reset until pixel_index has been nonzero.
- frame_cnt (4 b) increments on each tick. On a tick with frame_cnt==FRAME_DIV-1 it wraps to 0 and the FSM goes IDLE to UPDATE.
- FSM IDLE: spawn_ready = (slot_active != 4'hF).
  - Spawn accept (spawn_valid && spawn_ready) writes the lowest-index free slot: x = min(spawn_x, X_MAX), y = 0, active = 1.
- FSM UPDATE: visits slot 0,1,2,3, one per cycle, via a 2-bit index. spawn_ready = 0.
  - Active slot with y+1 == Y_MAX: clear active, set y to 0, pulse landed with landed_slot = index.
  - Other active slot: y <= y+1.
  - Inactive slot: unchanged.
  - After slot 3, the FSM returns to IDLE.
- Update/spawn collision: a tick entering UPDATE wins, and spawn_ready drops the same cycle the FSM leaves IDLE. A spawn held in valid waits; the handshake is never dropped.
- A tick arriving while in UPDATE still advances frame_cnt but does not restart the walk.
- Compositing:
  - Stage 1: row = pixel_index/96, col = pixel_index%96. Slot n hits if active, col in [x+2, x+9] and row in [y+2, y+11]. Register the lowest hit index and an any-hit flag. pixel_index > 6143 forces no hit.
  - Stage 2: oled_data <= any-hit ? slot_pix[selected] : BG_COLOUR.
- Hit compares use 8-bit sums so x+9 / y+11 never wrap.
- Positions update only in cycles registered by the FSM; renderers may see a moved egg mid-frame only on the tick-row pixels.

## Timing
- Spawn accept to slot_active/slot_x/slot_y update: 1 cycle.
- Tick to first UPDATE slot write: 2 cycles (tick detect, then slot 0). The UPDATE walk takes 4 cycles.
- landed is asserted in the same cycle as the slot_active clear, and lasts 1 cycle per landing.
- pixel_index at cycle t → oled_data valid at t+2, matching the 1-cycle renderer latency.
- Reset asserted mid-UPDATE: immediate return to reset values. No landed pulse is emitted.

## Structure
- Package egg_pkg:
  - SCREEN_W=96, SCREEN_H=64, NUM_PIXELS=6144.
  - Egg box offsets: COL_LO=2, COL_HI=9, ROW_LO=2, ROW_HI=11.
  - BG_COLOUR.
  - FSM state enum {IDLE, UPDATE}.
- Sub-module egg_slot_hit: combinational box comparator (row, col, x, y, active → hit), instantiated per slot.

## Test plan
- Reset, then spawn_valid with spawn_x=40 → slot 0 active, x=40, y=0, spawn_ready stays 1. A second spawn with spawn_x=120 → slot 1, x=86.
- Four spawns, then hold a fifth → spawn_ready=0, slot_active=4'hF, and the fifth is accepted only after a landing frees a slot.
- FRAME_DIV=4, drive full frames of pixel_index 0..6143 → slot 0 y increments once every 4 frames. At y=51 the next step gives landed=1, landed_slot=0, slot_active[0]=0.
- Spawn held valid across the tick that enters UPDATE → spawn_ready low for exactly the 4 UPDATE cycles plus the transition, then accepted into the lowest free slot.
- Slots 0 and 1 both at x=10, y=10 with distinct slot_pix, pixel_index=12*96+12 → oled_data = slot_pix[0] two cycles later. With pixel_index=0 → BG_COLOUR 16'hFDDB.
- Assert reset mid-UPDATE → all outputs return to reset values, no landed pulse, and normal operation resumes after release.
